pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised program-counter and hardware call-stack block for the next-generation 4-bit MCU core.
- PC = page field (PU) plus a low field (PL) that advances as an XNOR-feedback shift counter.
- Executes JMP, CALL, RET and long-page prefix (LPG) operations, one per step.
- Return stack has configurable depth with occupancy, full/empty and sticky error flags; the core sequencer drives it once per machine cycle.

Parameters:
- PL_W, 6, width of low PC field (shift counter).
- PU_W, 4, width of page field.
- TAP, 1, feedback tap index; feedback bit = PL[0] XNOR PL[TAP]; legal 1..PL_W-1.
- DEPTH, 5, number of return-stack entries (>=1).
- CALL_PAGE, all ones, page loaded by a CALL without prefix.
- TRAP_VEC, 0, {PU,PL} value used only when STACK_TRAP_EN is defined.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- step  in  1  advance one instruction this cycle; 0 = all state holds.
- op  in  3  0 NONE, 1 JMP, 2 CALL, 3 RET, 4 LPG, 5-7 treated as NONE.
- target  in  PL_W  JMP/CALL low-field target.
- page_in  in  PU_W  page value captured by LPG.
- pc  out  PU_W+PL_W  current {PU,PL}.
- depth  out  $clog2(DEPTH+1)  stack occupancy.
- stk_full  out  1  depth==DEPTH.
- stk_empty  out  1  depth==0.
- ovf_sticky  out  1  push attempted while full; cleared only by rst.
- unf_sticky  out  1  pop attempted while empty; cleared only by rst.
- trap  out  1  one-cycle pulse; exists only with STACK_TRAP_EN.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - pc=0, depth=0, stack entries=0, page latch=0, prefix flag=0, stickies=0, trap=0.
  - Outputs are registered; values apply from the cycle after the reset edge.
- adv(PL) = {PL[0] XNOR PL[TAP], PL[PL_W-1:1]}.
  - With defaults, period is 63.
  - All-ones is a fixed point; the PC stays there, and this is not an error.
- Each op below applies on an edge with step=1; results are visible the next cycle.
- NONE: PL<=adv(PL); PU unchanged.
- JMP:
  - PL<=target.
  - PU<=page latch if prefix armed, else PU unchanged.
- CALL:
  - Push {PU,adv(PL)} (the return address is the next sequential instruction).
  - PL<=target.
  - PU<=page latch if prefix armed, else CALL_PAGE.
  - depth+1, saturating at DEPTH.
- RET: pc<=top of stack; pop; depth-1.
- LPG:
  - Page latch<=page_in; prefix armed for the next stepped op only.
  - PL<=adv(PL); PU unchanged.
- Prefix flag: cleared by any stepped op other than LPG. LPG followed by LPG re-arms with the new page_in.
- Push while full:
  - Oldest entry discarded; the others shift down one slot; new entry goes on top.
  - depth stays DEPTH; ovf_sticky<=1.
- Pop while empty:
  - pc<=0; depth stays 0; unf_sticky<=1.
- step=0: no change anywhere, including the prefix flag.
- rst=1 overrides step and op in the same cycle.
- Stack storage is DEPTH registers of PU_W+PL_W bits. Only push/pop edges write them.

Optional Feature:
- Macro: STACK_TRAP_EN.
- Defined:
  - A push while full or pop while empty instead loads pc<=TRAP_VEC.
  - trap pulses high for the next cycle; stack contents and depth are unchanged; the sticky flag still sets.
  - Prefix flag cleared.
- Undefined: the trap port is absent, and the overflow/underflow behaviour above applies.

Test Plan:
- Reset, then 63 NONE steps -> PL sequence 0, 32, 48, 56, ..., back to 0 at step 63; PU=0 throughout.
- pc=0x005, CALL target=0x12 -> pc={0xF,0x12}, depth=1; then RET -> pc={0x0,adv(0x05)}=0x002, depth=0, stk_empty=1.
- LPG page_in=0x3, then JMP target=0x0A -> pc=0x0CA. LPG, NONE, JMP 0x0A -> PU unchanged.
- Six CALLs with DEPTH=5 -> depth=5, ovf_sticky=1, first return address lost. Five RETs return the 2nd..6th pushes in LIFO order; a 6th RET -> pc=0, unf_sticky=1.
- step=0 held 10 cycles with op=CALL -> pc, depth and flags unchanged. Assert rst mid-stack (depth=3) -> pc=0, depth=0, stickies cleared.
- STACK_TRAP_EN, TRAP_VEC=0x3C0, RET on empty -> pc=0x3C0, trap=1 for one cycle, depth=0, unf_sticky=1.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Sequencer-facing bus of the PC/return-stack unit: step/op controls in, PC and stack status out.
// Latency: none; plain wires, the unit registers everything.
// Backpressure: none; the sequencer pulses step at most once per machine cycle.
// Optional: STACK_TRAP_EN adds the trap pulse to the bus.
interface pc_stack_unit_if #(
  parameter int PL_W  = 6,
  parameter int PU_W  = 4,
  parameter int DEPTH = 5
);
  logic                         step;
  logic [2:0]                   op;
  logic [PL_W-1:0]              target;
  logic [PU_W-1:0]              page_in;
  logic [PU_W+PL_W-1:0]         pc;
  logic [$clog2(DEPTH+1)-1:0]   depth;
  logic                         stk_full;
  logic                         stk_empty;
  logic                         ovf_sticky;
  logic                         unf_sticky;
`ifdef STACK_TRAP_EN
  logic                         trap;
`endif

  modport master (
    output step, op, target, page_in,
    input  pc, depth, stk_full, stk_empty, ovf_sticky, unf_sticky
`ifdef STACK_TRAP_EN
    , input trap
`endif
  );

  modport slave (
    input  step, op, target, page_in,
    output pc, depth, stk_full, stk_empty, ovf_sticky, unf_sticky
`ifdef STACK_TRAP_EN
    , output trap
`endif
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter (page field + XNOR shift-counter low field) with LPG prefix and return stack.
// Latency: one cycle; all outputs are registered and show the result of the last stepped edge.
// Backpressure: none; step=0 freezes every register, the core sequencer paces the unit.
// Optional: define STACK_TRAP_EN to vector stack overflow/underflow to TRAP_VEC with a trap pulse.
module pc_stack_unit #(
  parameter int                    PL_W      = 6,
  parameter int                    PU_W      = 4,
  parameter int                    TAP       = 1,
  parameter int                    DEPTH     = 5,
  parameter logic [PU_W-1:0]       CALL_PAGE = '1,
  parameter logic [PU_W+PL_W-1:0]  TRAP_VEC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  pc_stack_unit_if.slave     bus
);
  localparam int PC_W = PU_W + PL_W;
  localparam int DW   = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_LPG  = 3'd4;

  logic [PU_W-1:0] pu_q;
  logic [PL_W-1:0] pl_q;
  logic [PU_W-1:0] page_q;
  logic            pfx_q;
  logic [PC_W-1:0] stk_q [DEPTH];
  logic [DW-1:0]   depth_q;
  logic            ovf_q;
  logic            unf_q;

  logic            is_full;
  logic            is_empty;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   push_idx;
  logic [PC_W-1:0] top_q;
  logic [PC_W-1:0] ret_addr;
  logic [PU_W-1:0] call_pu;

  // Next value of the low field in sequential flow; all-ones maps to itself.
  function automatic logic [PL_W-1:0] adv(input logic [PL_W-1:0] v);
    return {~(v[0] ^ v[TAP]), v[PL_W-1:1]};
  endfunction

  // Stack addressing and call/return values derived from current state.
  always_comb begin
    is_full  = (depth_q == DEPTH_V);
    is_empty = (depth_q == '0);
    top_idx  = IW'(depth_q - DW'(1));
    push_idx = IW'(depth_q);
    top_q    = stk_q[top_idx];
    ret_addr = {pu_q, adv(pl_q)};
    call_pu  = pfx_q ? page_q : CALL_PAGE;
  end

`ifdef STACK_TRAP_EN
  logic trap_q;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  // State update: reset wins, otherwise one instruction per stepped edge.
  always_ff @(posedge clk) begin
`ifdef STACK_TRAP_EN
    trap_q <= 1'b0;
`endif
    if (rst) begin
      pu_q    <= '0;
      pl_q    <= '0;
      page_q  <= '0;
      pfx_q   <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (bus.step) begin
      // The prefix only survives into the op right after LPG.
      pfx_q <= 1'b0;
      case (bus.op)
        OP_JMP: begin
          pl_q <= bus.target;
          if (pfx_q) pu_q <= page_q;
        end
        OP_CALL: begin
          pl_q <= bus.target;
          pu_q <= call_pu;
          if (!is_full) begin
            stk_q[push_idx] <= ret_addr;
            depth_q         <= depth_q + DW'(1);
          end else begin
            ovf_q <= 1'b1;
`ifdef STACK_TRAP_EN
            {pu_q, pl_q} <= TRAP_VEC;
            trap_q       <= 1'b1;
`else
            // Drop the oldest return address so the newest calls stay reachable.
            for (int i = 0; i < DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
            stk_q[DEPTH-1] <= ret_addr;
`endif
          end
        end
        OP_RET: begin
          if (!is_empty) begin
            {pu_q, pl_q} <= top_q;
            depth_q      <= depth_q - DW'(1);
          end else begin
            unf_q <= 1'b1;
`ifdef STACK_TRAP_EN
            {pu_q, pl_q} <= TRAP_VEC;
            trap_q       <= 1'b1;
`else
            {pu_q, pl_q} <= '0;
`endif
          end
        end
        OP_LPG: begin
          page_q <= bus.page_in;
          pfx_q  <= 1'b1;
          pl_q   <= adv(pl_q);
        end
        default: pl_q <= adv(pl_q);
      endcase
    end
  end

  assign bus.pc         = {pu_q, pl_q};
  assign bus.depth      = depth_q;
  assign bus.stk_full   = is_full;
  assign bus.stk_empty  = is_empty;
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
`ifdef STACK_TRAP_EN
  assign bus.trap       = trap_q;
`endif
endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios then random ops against a queue-based reference model.
// Latency: checks one cycle after each driven edge.
// Backpressure: step toggled randomly in the random phase.
module tb_pc_stack_unit;
  localparam int PL_W  = 6;
  localparam int PU_W  = 4;
  localparam int TAP   = 1;
  localparam int DEPTH = 5;
  localparam logic [PU_W+PL_W-1:0] TRAP_VEC = 10'h3C0;
  localparam int PL_MASK = (1 << PL_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_stack_unit_if #(.PL_W(PL_W), .PU_W(PU_W), .DEPTH(DEPTH)) bus ();

  pc_stack_unit #(
    .PL_W(PL_W), .PU_W(PU_W), .TAP(TAP), .DEPTH(DEPTH), .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state
  int m_pu, m_pl, m_latch;
  bit m_pfx, m_ovf, m_unf, m_trap;
  int m_stk[$];

  function automatic int madv(int pl);
    int fb;
    fb = (((pl & 1) == ((pl >> TAP) & 1)) ? 1 : 0);
    return (fb << (PL_W - 1)) | (pl >> 1);
  endfunction

  function automatic int mpc();
    return (m_pu << PL_W) | m_pl;
  endfunction

  task automatic model(bit r, bit s, int o, int t, int p);
    bit was_pfx;
    int a;
    m_trap = 0;
    if (r) begin
      m_pu = 0; m_pl = 0; m_latch = 0; m_pfx = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
    end else if (s) begin
      was_pfx = m_pfx;
      m_pfx = 0;
      case (o)
        1: begin
          m_pl = t;
          if (was_pfx) m_pu = m_latch;
        end
        2: begin
          a = (m_pu << PL_W) | madv(m_pl);
          if (m_stk.size() == DEPTH) m_ovf = 1;
`ifdef STACK_TRAP_EN
          if (m_stk.size() == DEPTH) begin
            m_pu = int'(TRAP_VEC) >> PL_W; m_pl = int'(TRAP_VEC) & PL_MASK; m_trap = 1;
          end else begin
            m_stk.push_back(a);
            m_pl = t; m_pu = was_pfx ? m_latch : (1 << PU_W) - 1;
          end
`else
          m_stk.push_back(a);
          if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
          m_pl = t; m_pu = was_pfx ? m_latch : (1 << PU_W) - 1;
`endif
        end
        3: begin
          if (m_stk.size() == 0) begin
            m_unf = 1;
`ifdef STACK_TRAP_EN
            m_pu = int'(TRAP_VEC) >> PL_W; m_pl = int'(TRAP_VEC) & PL_MASK; m_trap = 1;
`else
            m_pu = 0; m_pl = 0;
`endif
          end else begin
            a = m_stk.pop_back();
            m_pu = a >> PL_W; m_pl = a & PL_MASK;
          end
        end
        4: begin
          m_latch = p; m_pfx = 1; m_pl = madv(m_pl);
        end
        default: m_pl = madv(m_pl);
      endcase
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".pc"},    32'(bus.pc),         32'(mpc()));
    chk({tag, ".depth"}, 32'(bus.depth),      32'(m_stk.size()));
    chk({tag, ".full"},  32'(bus.stk_full),   32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.stk_empty),  32'(m_stk.size() == 0));
    chk({tag, ".ovf"},   32'(bus.ovf_sticky), 32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.unf_sticky), 32'(m_unf));
`ifdef STACK_TRAP_EN
    chk({tag, ".trap"},  32'(bus.trap),       32'(m_trap));
`endif
  endtask

  // Drive one cycle, advance the model at the edge, check 1 time unit later.
  task automatic cyc(string tag, bit r, bit s, int o, int t, int p);
    rst         = r;
    bus.step    = s;
    bus.op      = 3'(o);
    bus.target  = PL_W'(t);
    bus.page_in = PU_W'(p);
    @(posedge clk);
    model(r, s, o, t, p);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int first_zero;
    int save_pc;
    int o;

    // Reset and full shift-counter cycle
    cyc("reset", 1, 0, 0, 0, 0);
    chk("reset.pc_zero", 32'(bus.pc), 32'h0);
    first_zero = -1;
    for (int i = 1; i <= 63; i++) begin
      cyc("seq", 0, 1, 0, 0, 0);
      if (i == 1) chk("seq.step1", 32'(bus.pc), 32'h020);
      if (i == 2) chk("seq.step2", 32'(bus.pc), 32'h030);
      if (bus.pc == '0 && first_zero < 0) first_zero = i;
    end
    chk("seq.period", 32'(first_zero), 32'd63);

    // CALL / RET round trip
    cyc("rst2", 1, 0, 0, 0, 0);
    cyc("jmp5", 0, 1, 1, 5, 0);
    chk("jmp5.pc", 32'(bus.pc), 32'h005);
    cyc("call", 0, 1, 2, 6'h12, 0);
    chk("call.pc", 32'(bus.pc), 32'h3D2);
    chk("call.depth", 32'(bus.depth), 32'd1);
    cyc("ret", 0, 1, 3, 0, 0);
    chk("ret.pc", 32'(bus.pc), 32'h002);
    chk("ret.empty", 32'(bus.stk_empty), 32'd1);

    // Long-page prefix
    cyc("lpg3", 0, 1, 4, 0, 3);
    cyc("jmp_pfx", 0, 1, 1, 6'h0A, 0);
    chk("jmp_pfx.pc", 32'(bus.pc), 32'h0CA);
    cyc("lpg5", 0, 1, 4, 0, 5);
    cyc("none", 0, 1, 0, 0, 0);
    cyc("jmp_nopfx", 0, 1, 1, 6'h0A, 0);
    chk("jmp_nopfx.pc", 32'(bus.pc), 32'h0CA);

    // Overflow and underflow
    for (int i = 1; i <= 6; i++) cyc("call6", 0, 1, 2, i, 0);
    chk("call6.depth", 32'(bus.depth), 32'd5);
    chk("call6.ovf", 32'(bus.ovf_sticky), 32'd1);
    for (int i = 1; i <= 5; i++) cyc("ret5", 0, 1, 3, 0, 0);
`ifdef STACK_TRAP_EN
    chk("ret5.last", 32'(bus.pc), 32'h0C5);
`else
    chk("ret5.last", 32'(bus.pc), 32'h3C0);
`endif
    cyc("ret_empty", 0, 1, 3, 0, 0);
`ifdef STACK_TRAP_EN
    chk("ret_empty.pc", 32'(bus.pc), 32'h3C0);
`else
    chk("ret_empty.pc", 32'(bus.pc), 32'h000);
`endif
    chk("ret_empty.unf", 32'(bus.unf_sticky), 32'd1);

    // step=0 hold, then reset mid-stack
    for (int i = 0; i < 3; i++) cyc("call3", 0, 1, 2, 7 + i, 0);
    save_pc = mpc();
    for (int i = 0; i < 10; i++) begin
      cyc("hold", 0, 0, 2, 6'h3F, 0);
      chk("hold.pc", 32'(bus.pc), 32'(save_pc));
      chk("hold.depth", 32'(bus.depth), 32'd3);
    end
    cyc("rst_mid", 1, 1, 2, 1, 0);
    chk("rst_mid.pc", 32'(bus.pc), 32'h0);
    chk("rst_mid.depth", 32'(bus.depth), 32'd0);
    chk("rst_mid.ovf", 32'(bus.ovf_sticky), 32'd0);
    chk("rst_mid.unf", 32'(bus.unf_sticky), 32'd0);

`ifdef STACK_TRAP_EN
    cyc("trap_ret", 0, 1, 3, 0, 0);
    chk("trap_ret.pc", 32'(bus.pc), 32'h3C0);
    chk("trap_ret.trap", 32'(bus.trap), 32'd1);
    cyc("trap_after", 0, 1, 0, 0, 0);
    chk("trap_after.trap", 32'(bus.trap), 32'd0);
`endif

    // Random mix against the reference model
    for (int i = 0; i < 600; i++) begin
      o = $urandom_range(0, 7);
      cyc("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
          o, $urandom_range(0, PL_MASK), $urandom_range(0, (1 << PU_W) - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
